// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - note codes, frequency table and half-period helper for note_tone_gen
package tone_pkg;

    localparam int NOTE_W      = 5;
    localparam int NOTE_SILENT = 0;
    localparam int NOTE_MAX    = 21;

    // Tone frequencies in Hz for codes 1..21 (C4..B4, C5..B5, C6..B6).
    localparam int unsigned FREQ_HZ [NOTE_MAX] = '{
        262,  294,  330,  349,  392,  440,  494,
        523,  587,  659,  698,  784,  880,  988,
        1047, 1175, 1319, 1397, 1568, 1760, 1976
    };

    // Implicit operating state, derived from the registered note code.
    typedef enum logic {
        TONE_SILENT = 1'b0,
        TONE_ACTIVE = 1'b1
    } tone_state_e;

    // Truncated half-period in clk cycles; 0 for silent codes.
    function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned code);
        if (code == NOTE_SILENT || code > NOTE_MAX) begin
            return 0;
        end
        return clk_hz / (2 * FREQ_HZ[code - 1]);
    endfunction

    function automatic logic is_tone(input logic [NOTE_W-1:0] code);
        return (code != NOTE_W'(NOTE_SILENT)) && (code <= NOTE_W'(NOTE_MAX));
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// rtl/note_period_lut.sv - combinational ROM: note code -> half-period count
//   note_i : registered note code
//   half_o : half-period in clk cycles (0 for silent codes)
module note_period_lut
    import tone_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int CNT_W       = 17
) (
    input  logic [NOTE_W-1:0] note_i,
    output logic [CNT_W-1:0]  half_o
);

    logic [CNT_W-1:0] rom [2**NOTE_W];

    // Every entry is a constant evaluated at elaboration; an entry that does
    // not fit the counter stops elaboration.
    for (genvar g = 0; g < 2**NOTE_W; g++) begin : g_rom
        localparam int unsigned HALF = half_period(CLK_FREQ_HZ, g);
        if (64'(HALF) >= (64'd1 << CNT_W)) begin : g_overflow
            $error("note_period_lut: half-period %0d of code %0d does not fit CNT_W=%0d", HALF, g, CNT_W);
        end
        assign rom[g] = CNT_W'(HALF);
    end

    assign half_o = rom[note_i];

endmodule

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - note code to square-wave tone generator (optional TONE_VOLUME_EN)
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   note        : note code from sequencer, 0 and 22..31 silent
//   vol         : (TONE_VOLUME_EN only) 2-bit volume, duty 2/8..8/8 of the high phase
//   square_wave : registered tone output
//   tone_on     : registered note is a sounding code
module note_tone_gen
    import tone_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int CNT_W       = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NOTE_W-1:0] note,
`ifdef TONE_VOLUME_EN
    input  logic [1:0]        vol,
`endif
    output logic              square_wave,
    output logic              tone_on
);

    logic [NOTE_W-1:0] note_q;
    logic [NOTE_W-1:0] note_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_cur, half;
    logic              phase_q, phase_d;
    logic              sq_q, sq_d;
    logic              changed;
    tone_state_e       state;

    note_period_lut #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .CNT_W      (CNT_W)
    ) u_lut (
        .note_i(note_q),
        .half_o(half)
    );

    assign state   = is_tone(note_q) ? TONE_ACTIVE : TONE_SILENT;
    assign changed = (note_q != note_prev_q);
    // The change cycle itself is count 0 of the new half-period, so the
    // first edge after a change lands exactly `half` cycles later.
    assign cnt_cur = changed ? '0 : cnt_q;

    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        case (state)
            TONE_ACTIVE: begin
                phase_d = phase_q;
                if (cnt_cur == half - 1'b1) begin
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_cur + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end
        endcase
    end

`ifdef TONE_VOLUME_EN
    logic [1:0] vol_q;
    logic [2:0] pwm_q;
    logic [2:0] pwm_d;

    assign pwm_d = pwm_q + 3'd1;
    // Gate compares against the pwm value that will be current alongside sq_q.
    assign sq_d  = phase_d & ({1'b0, pwm_d} < (4'({vol_q, 1'b0}) + 4'd2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vol_q <= '0;
            pwm_q <= '0;
        end else begin
            vol_q <= vol;
            pwm_q <= pwm_d;
        end
    end
`else
    assign sq_d = phase_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_q      <= '0;
            note_prev_q <= '0;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            sq_q        <= 1'b0;
        end else begin
            note_q      <= note;
            note_prev_q <= note_q;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            sq_q        <= sq_d;
        end
    end

    assign square_wave = sq_q;
    assign tone_on     = (state == TONE_ACTIVE);

endmodule
